// File: rtl/clk_div_gen_if.sv
// Control and output bundle of the programmable clock-enable generator.
interface clk_div_gen_if #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned PCNT_W = 2
);
  logic              start;
  logic              stop;
  logic [DIV_W-1:0]  div_val;
  logic              clk_div;
  logic              rise_stb;
  logic              fall_stb;
  logic              busy;
  logic [PCNT_W-1:0] period_cnt;

  // Controller side: drives start/stop/ratio, observes the generated waveform.
  modport master (
    output start, stop, div_val,
    input  clk_div, rise_stb, fall_stb, busy, period_cnt
  );

  // Generator side.
  modport slave (
    input  start, stop, div_val,
    output clk_div, rise_stb, fall_stb, busy, period_cnt
  );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable clock-enable generator: divided square wave, edge strobes and a
// wrapping period count, all registered in the clk domain. Stops always finish
// the current period so no runt phase is produced.
module clk_div_gen #(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned PCNT_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  clk_div_gen_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [DIV_W-1:0] NMin = DIV_W'(2);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   n_q, n_d;
  logic               clk_div_q, clk_div_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               busy_q, busy_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;

  logic [DIV_W-1:0]   n_eff;
  logic [DIV_W-1:0]   hi_len;
  logic [DIV_W-1:0]   cnt_inc;
  logic               at_wrap;

  // Ratio clamp, high-phase length (ceil(N/2)) and wrap detect.
  always_comb begin
    n_eff   = (bus.div_val < NMin) ? NMin : bus.div_val;
    hi_len  = n_q - (n_q >> 1);
    cnt_inc = cnt_q + 1'b1;
    at_wrap = (cnt_q == n_q - 1'b1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    clk_div_d = clk_div_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    pcnt_d    = pcnt_q;
    unique case (state_q)
      StIdle: begin
        clk_div_d = 1'b0;
        // Stop has priority over a simultaneous start.
        if (bus.start && !bus.stop) begin
          state_d   = StRun;
          n_d       = n_eff;
          cnt_d     = '0;
          clk_div_d = 1'b1;
          rise_d    = 1'b1;
          pcnt_d    = '0;
        end
      end
      StRun, StDrain: begin
        if (at_wrap) begin
          pcnt_d = pcnt_q + 1'b1;
          cnt_d  = '0;
          if (state_q == StRun && !bus.stop) begin
            n_d       = n_eff;
            clk_div_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            state_d   = StIdle;
            clk_div_d = 1'b0;
          end
        end else begin
          cnt_d     = cnt_inc;
          clk_div_d = (cnt_inc < hi_len);
          fall_d    = (cnt_q == hi_len - 1'b1);
          if (state_q == StRun && bus.stop) begin
            state_d = StDrain;
          end else if (state_q == StDrain && bus.start) begin
            // Restart cancels the pending stop without touching the waveform.
            state_d = StRun;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        clk_div_d = 1'b0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset clears everything mid-period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      n_q       <= NMin;
      clk_div_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      clk_div_q <= clk_div_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign bus.clk_div    = clk_div_q;
  assign bus.rise_stb   = rise_q;
  assign bus.fall_stb   = fall_q;
  assign bus.busy       = busy_q;
  assign bus.period_cnt = pcnt_q;

endmodule
